// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state types for the multi-cycle ALU.
package alu_seq_pkg;

    localparam int OP_BITS = 4;

    typedef enum logic [OP_BITS-1:0] {
        OP_PASS   = 4'd0,
        OP_ADD    = 4'd1,
        OP_ADDC   = 4'd2,
        OP_SUB    = 4'd3,
        OP_XOR    = 4'd4,
        OP_OR     = 4'd5,
        OP_AND    = 4'd6,
        OP_SRL    = 4'd7,
        OP_SLL    = 4'd8,
        OP_CMP_EQ = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    function automatic logic is_shift(op_e op);
        return (op == OP_SRL) || (op == OP_SLL);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-file read side and writeback/branch logic.
// Handshake: a transfer happens on a rising edge where valid && ready are both high; a producer
// holds its payload stable while valid is high and ready is low.
interface alu_seq_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rslt;
    logic             wr_en;
    logic             sc;
    logic             zero;
    logic             pari;
    logic             eq;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, rslt, wr_en, sc, zero, pari, eq
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, rslt, wr_en, sc, zero, pari, eq
    );
endinterface

// File: rtl/alu_seq_logic.sv
// Single-cycle combinational operations; shifts here only cover the zero-amount case.
module alu_seq_logic
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sc_in,
    input  op_e              op,
    output logic [WIDTH-1:0] rslt,
    output logic             carry,
    output logic             carry_valid,
    output logic             wr_en
);
    logic [WIDTH:0] sum;

    always_comb begin
        sum         = '0;
        rslt        = '0;
        carry       = 1'b0;
        carry_valid = 1'b0;
        wr_en       = 1'b1;
        case (op)
            OP_PASS: rslt = b;
            OP_ADD: begin
                sum         = {1'b0, a} + {1'b0, b};
                rslt        = sum[WIDTH-1:0];
                carry       = sum[WIDTH];
                carry_valid = 1'b1;
            end
            OP_ADDC: begin
                sum         = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, sc_in};
                rslt        = sum[WIDTH-1:0];
                carry       = sum[WIDTH];
                carry_valid = 1'b1;
            end
            OP_SUB: begin
                // Carry out of a + ~b + 1 is the unsigned a >= b flag.
                sum         = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                rslt        = sum[WIDTH-1:0];
                carry       = sum[WIDTH];
                carry_valid = 1'b1;
            end
            OP_XOR:    rslt = a ^ b;
            OP_OR:     rslt = a | b;
            OP_AND:    rslt = a & b;
            OP_SRL:    rslt = a >> b[SH_W-1:0];
            OP_SLL:    rslt = a << b[SH_W-1:0];
            OP_CMP_EQ: wr_en = 1'b0;
            default:   wr_en = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: FSM, iterative shifter, persistent carry and registered result/flags.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = OP_BITS,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus,
    output state_e     dbg_state
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q;
    logic [SH_W-1:0]  count_q;
    logic             dir_left_q;
    logic [WIDTH-1:0] rslt_q;
    logic             wr_en_q, sc_q, zero_q, pari_q, eq_q;

    logic             in_ready, out_valid, accept;
    op_e              op_in;
    logic [SH_W-1:0]  sh_amt;
    logic             start_shift, last_shift;
    logic [WIDTH-1:0] work_next;
    logic             shadow;

    logic [WIDTH-1:0] lg_rslt;
    logic             lg_carry, lg_carry_valid, lg_wr_en;

    assign op_in       = op_e'(bus.op);
    assign sh_amt      = bus.b[SH_W-1:0];
    assign start_shift = is_shift(op_in) && (sh_amt != '0);
    assign last_shift  = (count_q == SH_W'(1));

    alu_seq_logic #(.WIDTH(WIDTH), .SH_W(SH_W)) u_logic (
        .a           (bus.a),
        .b           (bus.b),
        .sc_in       (sc_q),
        .op          (op_in),
        .rslt        (lg_rslt),
        .carry       (lg_carry),
        .carry_valid (lg_carry_valid),
        .wr_en       (lg_wr_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // flush wins over both a new accept and normal progress.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
            end
            default: ;
        endcase
        accept = bus.in_valid && in_ready && !bus.flush;
        case (state_q)
            IDLE: if (accept) state_d = start_shift ? SHIFT : HOLD;
            SHIFT: begin
                if (bus.flush)       state_d = IDLE;
                else if (last_shift) state_d = HOLD;
            end
            HOLD: begin
                if (bus.flush)          state_d = IDLE;
                else if (accept)        state_d = start_shift ? SHIFT : HOLD;
                else if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        work_next = dir_left_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
        shadow    = dir_left_q ? work_q[WIDTH-1] : work_q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q     <= '0;
            count_q    <= '0;
            dir_left_q <= 1'b0;
            rslt_q     <= '0;
            wr_en_q    <= 1'b0;
            sc_q       <= 1'b0;
            zero_q     <= 1'b0;
            pari_q     <= 1'b0;
            eq_q       <= 1'b0;
        end else if (accept) begin
            if (start_shift) begin
                work_q     <= bus.a;
                count_q    <= sh_amt;
                dir_left_q <= (op_in == OP_SLL);
            end else begin
                rslt_q  <= lg_rslt;
                wr_en_q <= lg_wr_en;
                zero_q  <= (lg_rslt == '0);
                pari_q  <= ^lg_rslt;
                if (lg_carry_valid)      sc_q <= lg_carry;
                if (op_in == OP_CMP_EQ)  eq_q <= (bus.a == bus.b);
            end
        end else if (state_q == SHIFT && !bus.flush) begin
            work_q  <= work_next;
            count_q <= count_q - SH_W'(1);
            if (last_shift) begin
                rslt_q  <= work_next;
                wr_en_q <= 1'b1;
                zero_q  <= (work_next == '0);
                pari_q  <= ^work_next;
                sc_q    <= shadow;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.rslt      = rslt_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.sc        = sc_q;
    assign bus.zero      = zero_q;
    assign bus.pari      = pari_q;
    assign bus.eq        = eq_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: arithmetic model + per-cycle compare process + literal checks.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 8;

    logic   clk = 1'b0;
    logic   rst_n;
    state_e dbg_state;

    alu_seq_if #(.WIDTH(W), .OP_W(4)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [12:0] exp_q[$];
    logic        m_sc, m_eq;
    logic        acc_neg = 1'b0;
    int          cur_op, cur_a, cur_b;
    int          n, lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packed expectation: {rslt[7:0], wr_en, sc, zero, pari, eq}
    function automatic logic [12:0] model(input int op, input int a, input int b);
        int r, k;
        logic s, e, we;
        logic [7:0] rv;
        r = 0; s = m_sc; e = m_eq; we = 1'b1; k = b % W;
        case (op)
            0: r = b;
            1: begin r = (a + b) % 256; s = (a + b) > 255; end
            2: begin r = (a + b + int'(m_sc)) % 256; s = (a + b + int'(m_sc)) > 255; end
            3: begin r = (a - b + 256) % 256; s = (a >= b); end
            4: r = a ^ b;
            5: r = a | b;
            6: r = a & b;
            7: begin r = a >> k; if (k > 0) s = ((a >> (k - 1)) % 2) == 1; end
            8: begin r = (a << k) % 256; if (k > 0) s = ((a >> (W - k)) % 2) == 1; end
            9: begin r = 0; e = (a == b); we = 1'b0; end
            default: begin r = 0; we = 1'b0; end
        endcase
        rv = r[7:0];
        return {rv, we, s, (rv == 8'h00), ^rv, e};
    endfunction

    always @(negedge clk) acc_neg <= bus.in_valid && bus.in_ready && !bus.flush;

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                check("model_out", {19'd0, bus.rslt, bus.wr_en, bus.sc, bus.zero, bus.pari, bus.eq},
                      {19'd0, exp_q[0]});
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input int a, input int b);
        cur_op = op; cur_a = a; cur_b = b;
        bus.in_valid = 1'b1;
        bus.op       = op[3:0];
        bus.a        = a[W-1:0];
        bus.b        = b[W-1:0];
    endtask

    task automatic accept_wait(input bit push, output int cyc);
        logic [12:0] e;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
        end while (!acc_neg && cyc < 50);
        check("accept", {31'd0, acc_neg}, 32'd1);
        #1;
        bus.in_valid = 1'b0;
        if (push) begin
            e = model(cur_op, cur_a, cur_b);
            exp_q.push_back(e);
            m_sc = e[3];
            m_eq = e[0];
        end
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.out_valid && cyc < 50);
        check("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic run_op(input int op, input int a, input int b, input int exp_lat);
        step();
        drive(op, a, b);
        accept_wait(1'b1, n);
        wait_out(lat);
        check("latency", lat, exp_lat);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        m_sc = 1'b0; m_eq = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_rslt", {24'd0, bus.rslt}, 0);
        check("rst_flags", {27'd0, bus.wr_en, bus.sc, bus.zero, bus.pari, bus.eq}, 0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 1);
        step();
        rst_n = 1'b1;

        run_op(1, 'hF0, 'h20, 1);
        check("add_rslt", {24'd0, bus.rslt}, 'h10);
        check("add_sc_zero_pari", {29'd0, bus.sc, bus.zero, bus.pari}, 3'b101);
        run_op(2, 'h01, 'h00, 1);
        check("addc_rslt", {24'd0, bus.rslt}, 'h02);
        check("addc_sc", {31'd0, bus.sc}, 0);

        run_op(7, 'hB5, 3, 4);
        check("srl_rslt", {24'd0, bus.rslt}, 'h16);
        check("srl_sc", {31'd0, bus.sc}, 1);
        run_op(7, 'h5A, 0, 1);
        check("srl0_rslt", {24'd0, bus.rslt}, 'h5A);
        check("srl0_sc", {31'd0, bus.sc}, 1);
        run_op(8, 'h21, 2, 3);
        check("sll_rslt", {24'd0, bus.rslt}, 'h84);
        check("sll_sc", {31'd0, bus.sc}, 0);

        // Back-to-back with out_ready held high
        step();
        drive(4, 'hFF, 'hFF);
        accept_wait(1'b1, n);
        drive(5, 'h0F, 'hF0);
        @(negedge clk);
        check("b2b_xor_valid", {31'd0, bus.out_valid}, 1);
        check("b2b_xor", {23'd0, bus.rslt, bus.zero}, {23'd0, 8'h00, 1'b1});
        accept_wait(1'b1, n);
        check("b2b_or_accept_cycles", n, 1);
        @(negedge clk);
        check("b2b_or_valid", {31'd0, bus.out_valid}, 1);
        check("b2b_or", {23'd0, bus.rslt, bus.pari}, {23'd0, 8'hFF, 1'b0});

        // Backpressure on SUB
        step();
        bus.out_ready = 1'b0;
        drive(3, 'h05, 'h07);
        accept_wait(1'b1, n);
        wait_out(lat);
        check("sub_lat", lat, 1);
        drive(0, 0, 'h33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, bus.out_valid}, 1);
            check("bp_rslt_sc", {23'd0, bus.rslt, bus.sc}, {23'd0, 8'hFE, 1'b0});
            check("bp_in_ready", {31'd0, bus.in_ready}, 0);
        end
        step();
        bus.out_ready = 1'b1;
        accept_wait(1'b1, n);
        check("bp_release_accept_cycles", n, 1);
        wait_out(lat);
        check("pass_rslt", {24'd0, bus.rslt}, 'h33);

        run_op(1, 'hFF, 'h01, 1);
        check("add_wrap", {22'd0, bus.rslt, bus.sc, bus.zero}, {22'd0, 8'h00, 2'b11});
        run_op(9, 'h3C, 'h3C, 1);
        check("cmp_eq", {27'd0, bus.eq, bus.wr_en, bus.sc, bus.zero, bus.pari}, 5'b10110);
        check("cmp_rslt", {24'd0, bus.rslt}, 0);

        // flush mid-shift: no result, sc/eq untouched
        step();
        drive(8, 'h01, 6);
        accept_wait(1'b0, n);
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("flush_no_valid", {31'd0, bus.out_valid}, 0);
        end
        check("flush_sc_eq", {30'd0, bus.sc, bus.eq}, 2'b11);
        check("flush_state", {30'd0, dbg_state}, {30'd0, IDLE});

        run_op(12, 'h01, 'h02, 1);
        check("illegal", {21'd0, bus.rslt, bus.wr_en, bus.sc, bus.eq}, {21'd0, 8'h00, 3'b011});
        run_op(9, 'h3C, 'h3D, 1);
        check("cmp_ne_eq", {31'd0, bus.eq}, 0);

        // flush in IDLE blocks that cycle's accept
        step();
        drive(0, 0, 'h77);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        check("idle_flush_blocks", {31'd0, bus.out_valid}, 0);
        accept_wait(1'b1, n);
        check("idle_flush_then_accept", n, 1);
        wait_out(lat);
        check("after_flush_rslt", {24'd0, bus.rslt}, 'h77);

        // Async reset in the middle of a long shift
        step();
        drive(7, 'h80, 7);
        accept_wait(1'b0, n);
        step();
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {18'd0, bus.out_valid, bus.rslt, bus.wr_en, bus.sc, bus.zero, bus.pari, bus.eq}, 0);
        exp_q.delete();
        m_sc = 1'b0;
        m_eq = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 1);
        check("midrst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        run_op(2, 'h01, 'h01, 1);
        check("post_rst_addc", {23'd0, bus.rslt, bus.sc}, {23'd0, 8'h02, 1'b0});

        step();
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Performs arithmetic, logic, compare and pass operations on WIDTH-bit operands.
- Carry persists across instructions, so adds can be chained with carry.
- Shifts are iterative (one bit per cycle), and results and flags are registered.
- Sits between the register file read ports and the writeback/branch logic, with valid/ready handshakes on both sides so the control unit can stall on multi-cycle ops.

Parameters:
- WIDTH, 8: operand and result width in bits, ≥2.
- OP_W, 4: opcode width.
- SH_W, $clog2(WIDTH): width of the shift-amount field, taken from b[SH_W-1:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- op  input  OP_W  opcode (see Behaviour).
- a  input  WIDTH  operand A (register 2 value).
- b  input  WIDTH  operand B (register 3 value or immediate).
- flush  input  1  synchronous abort of any in-flight operation.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- rslt  output  WIDTH  registered result.
- wr_en  output  1  result must be written back; 0 for CMP_EQ and illegal ops.
- sc  output  1  persistent carry/shift-out flag.
- zero  output  1  rslt == 0, registered with rslt.
- pari  output  1  reduction XOR of rslt.
- eq  output  1  result of the last CMP_EQ, held until the next CMP_EQ.

Behaviour:
- Reset (rst_n low, any time, including mid-shift):
  - state=IDLE.
  - rslt, wr_en, sc, zero, pari, eq, out_valid all 0.
  - The in-flight operation is lost.
- Opcodes:
  - 0 PASS: rslt=b.
  - 1 ADD: {sc,rslt}=a+b.
  - 2 ADDC: {sc,rslt}=a+b+sc.
  - 3 SUB: rslt=a-b, sc=(a>=b) unsigned.
  - 4 XOR, 5 OR, 6 AND: bitwise on a and b.
  - 7 SRL: a>>b[SH_W-1:0].
  - 8 SLL: a<<b[SH_W-1:0].
  - 9 CMP_EQ: rslt=0, eq=(a==b), wr_en=0, sc unchanged.
  - 10-15 illegal: rslt=0, wr_en=0, sc and eq unchanged.
- Flag rules:
  - sc changes only on ops 1, 2, 3, 7, 8.
  - For shifts, sc = last bit shifted out; shift amount 0 leaves sc unchanged.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - HOLD: out_valid=1; in_ready=out_ready.
- Accept condition: in_valid && in_ready.
- Non-shift ops, or a shift with amount 0:
  - Computed combinationally and registered at the accept edge.
  - Next state is HOLD, so out_valid rises one cycle after accept.
- Shift ops with amount k>0:
  - At the accept edge: work register ← a, count ← k, state ← SHIFT.
  - Each SHIFT cycle: shift work by 1 in the selected direction, capture the bit shifted out into a shadow bit, decrement count.
  - When count reaches 1, the same edge loads rslt/zero/pari, updates sc from the shadow bit, and moves to HOLD.
  - Total latency from accept to out_valid is k+1 cycles.
- HOLD:
  - rslt and flags stay stable until out_ready.
  - out_ready && in_valid: the new op is accepted in the same cycle (back-to-back, throughput 1 for non-shift ops).
  - out_ready && !in_valid: go to IDLE.
- flush:
  - In SHIFT or HOLD: go to IDLE next edge, out_valid=0, sc/eq not updated by the aborted op.
  - flush overrides accept in the same cycle.
  - In IDLE it is a no-op and blocks accept that cycle.
- Width: all arithmetic is modulo 2^WIDTH; the carry is bit WIDTH of the (WIDTH+1)-bit sum.
- SUB uses a + ~b + 1.

Decomposition:
- Package alu_seq_pkg:
  - op_e enum (OP_PASS..OP_CMP_EQ) with OP_W.
  - state_e enum (IDLE, SHIFT, HOLD).
  - Function is_shift(op_e).
- Sub-module alu_seq_logic: purely combinational single-cycle ops.
  - Inputs: a, b, sc_in, op.
  - Outputs: rslt, carry, carry_valid, wr_en.
- The top holds the FSM, shift register, counter and flag registers.

Test Plan:
- Reset mid-shift: SRL a=8'h80, b=7, assert rst_n low at cycle 3 → all outputs 0, in_ready=1 after release, sc=0.
- ADD 8'hF0+8'h20 → rslt=8'h10, sc=1, zero=0, pari=1 one cycle after accept. Then ADDC 8'h01+8'h00 → rslt=8'h02, sc=0.
- SRL a=8'b1011_0101, b=3 → out_valid 4 cycles after accept, rslt=8'b0001_0110, sc=1. Shift with b=0 → 1-cycle latency, rslt=a, sc unchanged.
- Back-to-back: XOR 8'hFF^8'hFF then OR 8'h0F|8'hF0 with out_ready=1 → consecutive out_valid cycles. Results: 8'h00 with zero=1, then 8'hFF with pari=0.
- Backpressure: out_ready=0 for 5 cycles after SUB 8'h05-8'h07 → rslt=8'hFE and sc=0 stable, in_ready=0. Release → next op accepted the same cycle.
- CMP_EQ 8'h3C vs 8'h3C → eq=1, wr_en=0, sc unchanged. flush during SLL b=6 at cycle 2 → no out_valid, sc and eq unchanged.
